// File: rtl/mem_pkg.sv
// Shared data-memory constants and store-buffer types.
package mem_pkg;

    localparam int unsigned MEM_ADDR_W = 4;
    localparam int unsigned MEM_DATA_W = 8;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] data;
    } store_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        DONE
    } sync_state_t;

endpackage

// File: rtl/store_buffer_if.sv
// Store request, memory write, lookup and sync signals of the store buffer.
interface store_buffer_if
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              drain_enable;
    logic              mem_write_enable;
    logic [ADDR_W-1:0] mem_write_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic [ADDR_W-1:0] lookup_addr_1;
    logic [ADDR_W-1:0] lookup_addr_2;
    logic              hit_1;
    logic [DATA_W-1:0] hit_data_1;
    logic              hit_2;
    logic [DATA_W-1:0] hit_data_2;
    logic              sync_req;
    logic              sync_done;
    logic [CNT_W-1:0]  count;
    logic              empty;

    modport master (
        output in_valid, in_addr, in_data, drain_enable,
               lookup_addr_1, lookup_addr_2, sync_req,
        input  in_ready, mem_write_enable, mem_write_addr, mem_write_data,
               hit_1, hit_data_1, hit_2, hit_data_2, sync_done, count, empty
    );

    modport slave (
        input  in_valid, in_addr, in_data, drain_enable,
               lookup_addr_1, lookup_addr_2, sync_req,
        output in_ready, mem_write_enable, mem_write_addr, mem_write_data,
               hit_1, hit_data_1, hit_2, hit_data_2, sync_done, count, empty
    );

endinterface

// File: rtl/store_buffer_lookup.sv
// Youngest-match search of the pending stores for one load address.
module store_buffer_lookup
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  store_entry_t          entries [DEPTH],
    input  logic [DEPTH-1:0]      valid,
    input  logic [PTR_W-1:0]      head,
    input  logic [MEM_ADDR_W-1:0] addr,
    output logic                  hit_c,
    output logic [MEM_DATA_W-1:0] hit_data_c
);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        hit_c      = 1'b0;
        hit_data_c = '0;
        idx        = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (valid[idx] && (entries[idx].addr == addr)) begin
                hit_c      = 1'b1;
                hit_data_c = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// FIFO store buffer in front of the 16x8 data memory with load forwarding and sync drain.
module store_buffer
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W
) (
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave sb
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    store_entry_t     entry_q [DEPTH];
    store_entry_t     entry_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    sync_state_t      state_q, state_d;
    logic             armed_q, armed_d;

    logic             full_c, empty_c, push_c, pop_c;
    store_entry_t     head_entry_c;
    logic [MEM_DATA_W-1:0] hit_data_1_c, hit_data_2_c;

    assign full_c  = (count_q == CNT_W'(DEPTH));
    assign empty_c = (count_q == '0);
    // Reset gates ready directly so it reads 0 while reset is held.
    assign sb.in_ready = reset && !full_c && (state_q == IDLE);
    assign push_c      = sb.in_valid && sb.in_ready;
    assign pop_c       = !empty_c && sb.drain_enable;
    assign head_entry_c = empty_c ? '0 : entry_q[head_q];

    assign sb.mem_write_enable = pop_c;
    assign sb.mem_write_addr   = ADDR_W'(head_entry_c.addr);
    assign sb.mem_write_data   = DATA_W'(head_entry_c.data);
    assign sb.count            = count_q;
    assign sb.empty            = empty_c;
    assign sb.sync_done        = (state_q == DONE);
    assign sb.hit_data_1       = DATA_W'(hit_data_1_c);
    assign sb.hit_data_2       = DATA_W'(hit_data_2_c);

    // FIFO bookkeeping and sync FSM next state.
    always_comb begin
        entry_d = entry_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        state_d = state_q;
        armed_d = armed_q || !sb.sync_req;

        if (push_c) begin
            entry_d[tail_q] = '{addr: MEM_ADDR_W'(sb.in_addr), data: MEM_DATA_W'(sb.in_data)};
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        if (pop_c) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (sb.sync_req && armed_q) begin
                    state_d = DRAIN;
                    armed_d = 1'b0;
                end
            end
            DRAIN: begin
                if (empty_c || ((count_q == CNT_W'(1)) && pop_c)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_q[i] <= '0;
            end
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= IDLE;
            armed_q <= 1'b1;
        end else begin
            entry_q <= entry_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
            armed_q <= armed_d;
        end
    end

    store_buffer_lookup #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_lookup_1 (
        .entries    (entry_q),
        .valid      (valid_q),
        .head       (head_q),
        .addr       (MEM_ADDR_W'(sb.lookup_addr_1)),
        .hit_c      (sb.hit_1),
        .hit_data_c (hit_data_1_c)
    );

    store_buffer_lookup #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_lookup_2 (
        .entries    (entry_q),
        .valid      (valid_q),
        .head       (head_q),
        .addr       (MEM_ADDR_W'(sb.lookup_addr_2)),
        .hit_c      (sb.hit_2),
        .hit_data_c (hit_data_2_c)
    );

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected memory writes queued at push, checked by a monitor.
module tb_store_buffer;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    logic [11:0] exp_q[$];

    store_buffer_if #(.DEPTH(4), .ADDR_W(4), .DATA_W(8)) sb ();

    store_buffer #(.DEPTH(4), .ADDR_W(4), .DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_store(input logic [3:0] a, input logic [7:0] d);
        sb.in_addr  = a;
        sb.in_data  = d;
        sb.in_valid = 1'b1;
        #1;
        check("push_ready", 32'(sb.in_ready), 32'd1);
        exp_q.push_back({a, d});
        step();
        sb.in_valid = 1'b0;
    endtask

    // Monitor: every memory write must match the oldest outstanding store.
    initial begin
        logic [11:0] exp_w;
        forever begin
            @(negedge clk);
            if (sb.mem_write_enable === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                             sb.mem_write_addr, sb.mem_write_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("write_addr", 32'(sb.mem_write_addr), 32'(exp_w[11:8]));
                    check("write_data", 32'(sb.mem_write_data), 32'(exp_w[7:0]));
                end
            end
        end
    end

    initial begin
        int pulses;
        int pulse_at;
        tests = 0;
        fails = 0;
        reset            = 1'b0;
        sb.in_valid      = 1'b0;
        sb.in_addr       = '0;
        sb.in_data       = '0;
        sb.drain_enable  = 1'b1;
        sb.lookup_addr_1 = 4'd3;
        sb.lookup_addr_2 = 4'd4;
        sb.sync_req      = 1'b0;
        #1;
        check("rst_in_ready", 32'(sb.in_ready), 32'd0);
        check("rst_empty", 32'(sb.empty), 32'd1);
        check("rst_mem_we", 32'(sb.mem_write_enable), 32'd0);
        check("rst_sync_done", 32'(sb.sync_done), 32'd0);
        repeat (2) step();
        reset = 1'b1;

        // Idle after reset
        for (int i = 0; i < 3; i++) begin
            #1;
            check("idle_in_ready", 32'(sb.in_ready), 32'd1);
            check("idle_empty", 32'(sb.empty), 32'd1);
            check("idle_mem_we", 32'(sb.mem_write_enable), 32'd0);
            check("idle_hit_1", 32'(sb.hit_1), 32'd0);
            check("idle_waddr", 32'(sb.mem_write_addr), 32'd0);
            step();
        end

        // Single store, forward, then drain
        sb.drain_enable = 1'b0;
        push_store(4'd3, 8'hA5);
        #1;
        check("single_count", 32'(sb.count), 32'd1);
        check("single_hit", 32'(sb.hit_1), 32'd1);
        check("single_hit_data", 32'(sb.hit_data_1), 32'hA5);
        check("single_miss_2", 32'(sb.hit_2), 32'd0);
        check("single_miss_data_2", 32'(sb.hit_data_2), 32'd0);
        sb.drain_enable = 1'b1;
        #1;
        check("single_we", 32'(sb.mem_write_enable), 32'd1);
        step();
        sb.drain_enable = 1'b0;
        #1;
        check("single_empty", 32'(sb.empty), 32'd1);
        check("single_hit_gone", 32'(sb.hit_1), 32'd0);

        // Duplicate address: youngest forwarded, both written in order
        sb.lookup_addr_1 = 4'd5;
        push_store(4'd5, 8'h11);
        push_store(4'd5, 8'h22);
        #1;
        check("dup_count", 32'(sb.count), 32'd2);
        check("dup_hit_data", 32'(sb.hit_data_1), 32'h22);
        sb.drain_enable = 1'b1;
        #1;
        check("dup_hit_while_pop", 32'(sb.hit_data_1), 32'h22);
        step();
        check("dup_count_1", 32'(sb.count), 32'd1);
        check("dup_hit_data_1", 32'(sb.hit_data_1), 32'h22);
        step();
        check("dup_empty", 32'(sb.empty), 32'd1);
        check("dup_hit_gone", 32'(sb.hit_1), 32'd0);
        sb.drain_enable = 1'b0;

        // Fill to DEPTH, hold a fifth request, then pop once
        push_store(4'd1, 8'h10);
        push_store(4'd2, 8'h20);
        push_store(4'd3, 8'h30);
        push_store(4'd4, 8'h40);
        sb.in_addr  = 4'd7;
        sb.in_data  = 8'h77;
        sb.in_valid = 1'b1;
        #1;
        check("full_ready", 32'(sb.in_ready), 32'd0);
        check("full_count", 32'(sb.count), 32'd4);
        step();
        step();
        sb.lookup_addr_1 = 4'd7;
        sb.lookup_addr_2 = 4'd2;
        #1;
        check("full_count_hold", 32'(sb.count), 32'd4);
        check("full_no_fwd_in", 32'(sb.hit_1), 32'd0);
        check("full_hit_2", 32'(sb.hit_2), 32'd1);
        check("full_hit_data_2", 32'(sb.hit_data_2), 32'h20);
        sb.drain_enable = 1'b1;
        step();
        sb.in_valid     = 1'b0;
        sb.drain_enable = 1'b0;
        #1;
        check("full_pop_count", 32'(sb.count), 32'd3);
        check("full_pop_ready", 32'(sb.in_ready), 32'd1);

        // Sync with three entries
        sb.drain_enable = 1'b1;
        sb.sync_req     = 1'b1;
        pulses   = 0;
        pulse_at = 0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 1) begin
                sb.sync_req = 1'b0;
                check("sync_ready_low", 32'(sb.in_ready), 32'd0);
            end
            if (sb.sync_done === 1'b1) begin
                pulses++;
                pulse_at = i;
            end
            if (i == 4) check("sync_ready_back", 32'(sb.in_ready), 32'd1);
        end
        check("sync_pulses", 32'(pulses), 32'd1);
        check("sync_pulse_cycle", 32'(pulse_at), 32'd3);
        check("sync_empty", 32'(sb.empty), 32'd1);

        // Sync on empty buffer with request held high: exactly one pulse
        sb.sync_req = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (sb.sync_done === 1'b1) pulses++;
        end
        check("sync_hold_pulses", 32'(pulses), 32'd1);
        check("sync_hold_ready", 32'(sb.in_ready), 32'd1);
        sb.sync_req = 1'b0;
        step();

        // Reset mid-DRAIN with two pending stores
        sb.drain_enable = 1'b0;
        push_store(4'd8, 8'h81);
        push_store(4'd9, 8'h92);
        sb.sync_req = 1'b1;
        step();
        sb.sync_req = 1'b0;
        check("rstd_ready_low", 32'(sb.in_ready), 32'd0);
        sb.drain_enable = 1'b1;
        #1;
        check("rstd_we_before", 32'(sb.mem_write_enable), 32'd1);
        reset = 1'b0;
        #1;
        check("rstd_we_async", 32'(sb.mem_write_enable), 32'd0);
        check("rstd_empty", 32'(sb.empty), 32'd1);
        exp_q.delete();
        repeat (2) step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rstd_no_done", 32'(sb.sync_done), 32'd0);
            check("rstd_count", 32'(sb.count), 32'd0);
            step();
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Small FIFO store buffer directly upstream of the 16x8 data memory.
- Accepts store requests through a valid/ready handshake and drains one store per cycle into the memory write port whenever drain_enable permits.
- Forwards the youngest pending store data to both memory read ports' lookup addresses, so loads observe stores that have not yet been written.
- Provides a sync (drain-all) request with a completion pulse.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, ≥2.
- ADDR_W, 4, store address width; matches the data memory depth of 16.
- DATA_W, 8, store data width; matches the data memory word.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  store request valid.
- in_ready  output  1  buffer can accept a store this cycle.
- in_addr  input  ADDR_W  store address.
- in_data  input  DATA_W  store data.
- drain_enable  input  1  memory write port is available this cycle.
- mem_write_enable  output  1  to the data memory write_enable.
- mem_write_addr  output  ADDR_W  to the data memory write_addr.
- mem_write_data  output  DATA_W  to the data memory write_data.
- lookup_addr_1  input  ADDR_W  same value as data memory read_addr_1.
- lookup_addr_2  input  ADDR_W  same value as data memory read_addr_2.
- hit_1  output  1  a pending store matches lookup_addr_1.
- hit_data_1  output  DATA_W  youngest matching pending data for lookup_addr_1; 0 if no hit.
- hit_2  output  1  a pending store matches lookup_addr_2.
- hit_data_2  output  DATA_W  youngest matching pending data for lookup_addr_2; 0 if no hit.
- sync_req  input  1  request to drain the buffer completely.
- sync_done  output  1  one-cycle pulse when the requested drain completes.
- count  output  $clog2(DEPTH)+1  number of occupied entries.
- empty  output  1  count == 0.

Behaviour:
- Reset (reset low, asynchronous):
  - Pointers and count cleared; all entries invalidated; FSM goes to IDLE.
  - mem_write_enable=0, in_ready=0, hit_1=hit_2=0, sync_done=0, empty=1.
  - Pending stores are discarded without being written.
- After reset release: in_ready=1 from the first cycle.
- Push: occurs on a rising edge when in_valid && in_ready. Entry {in_addr, in_data} is stored at the tail.
- in_ready = !full && state==IDLE. It does not depend on a same-cycle pop, so there is no ready-through path.
- Pop:
  - mem_write_enable = !empty && drain_enable (combinational).
  - mem_write_addr and mem_write_data always reflect the head entry; they are 0 when empty.
  - The head is popped at the same edge at which the memory captures the write.
- Latency: a store pushed at edge N is at the head no earlier than N+1, and is written to memory at edge N+1 at the earliest if the buffer was empty.
- Simultaneous push and pop: count is unchanged, both pointers advance.
- Full with a pop: no push that cycle, because in_ready=0.
- Pointer wrap-around: modulo DEPTH, with an extra wrap bit or count to distinguish full from empty.
- Order: writes reach memory in strict FIFO order. There is no coalescing; duplicate addresses are written in sequence.
- Forwarding (combinational):
  - Searches all valid entries, including the head being popped this cycle.
  - The youngest matching entry wins.
  - The in_data presented this cycle is never forwarded.
  - Both lookups are independent and may hit the same entry.
- Sync FSM:
  - IDLE: if sync_req, go to DRAIN; any push at that edge is still accepted.
  - DRAIN: in_ready=0. When count==0, or count==1 with a pop this cycle, go to DONE.
  - DONE: sync_done=1 for exactly one cycle, then return to IDLE.
  - sync_req held high in DONE does not retrigger until it has been seen low.
  - sync_req with the buffer already empty: IDLE→DRAIN→DONE, so sync_done asserts 2 cycles after the request edge.
  - drain_enable low during DRAIN: the FSM stays in DRAIN indefinitely.
- Reset mid-DRAIN: FSM returns to IDLE and no sync_done pulse is generated.

Decomposition:
- Shared package mem_pkg:
  - constants MEM_ADDR_W=4 and MEM_DATA_W=8;
  - typedef store_entry_t, a packed struct of {addr, data};
  - typedef sync_state_t, an enum of IDLE, DRAIN, DONE.
- One combinational sub-module, store_buffer_lookup:
  - inputs: entry array, valid mask, head pointer, lookup address;
  - outputs: hit and youngest-match data;
  - instantiated twice, once per lookup port.

Test Plan:
- Reset then idle, drain_enable=1: in_ready=1, empty=1, mem_write_enable=0, hit_1=0 throughout.
- Push addr 3/data 0xA5 with drain_enable=0: count=1. lookup_addr_1=3 gives hit_1=1, hit_data_1=0xA5. Raise drain_enable: write addr 3/0xA5 in one cycle, then empty=1.
- Push addr 5/0x11 then addr 5/0x22 with drain_enable=0: lookup 5 gives 0x22. Memory receives 0x11 then 0x22 on consecutive drain cycles; hit_data shows 0x22 until both are gone.
- Fill DEPTH=4 with drain_enable=0: in_ready=0 and count=4. Hold in_valid: no fifth push. Enable drain for 1 cycle: count=3 and in_ready=1.
- Sync with 3 entries and drain_enable=1: in_ready=0 immediately after the request edge. sync_done pulses once on the cycle after the last write; in_ready returns to 1 after the pulse.
- Assert reset with 2 entries pending mid-DRAIN: mem_write_enable drops asynchronously. After release, count=0, no sync_done, and the dropped stores are never written.
